// File: rtl/eva_knn_pkg.sv
// Shared definitions for the EVA k-NN vote stage.
// Holds the FSM state encoding, the default widths, the class count and
// the clamp that maps a requested k onto the range 1..Number.
package eva_knn_pkg;

    localparam int unsigned NUMBER      = 16;
    localparam int unsigned IDX_W       = 4;
    localparam int unsigned LABEL_W     = 2;
    localparam int unsigned CNT_W       = 5;
    localparam int unsigned NUM_CLASSES = 1 << LABEL_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_SCAN  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // k=0 still votes with the single nearest sample; k beyond the sample
    // count votes with every sample.
    function automatic logic [CNT_W-1:0] clamp_k(input logic [CNT_W-1:0] k,
                                                 input int unsigned number);
        logic [CNT_W-1:0] r;
        r = k;
        if (k == '0) begin
            r = CNT_W'(1);
        end else if (32'(k) > number) begin
            r = CNT_W'(number);
        end
        return r;
    endfunction

endpackage

// File: rtl/eva_vote_tally.sv
// Per-class vote counter bank.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   clear      - zero every counter (takes priority over inc)
//   inc        - add one vote to the counter chosen by inc_sel
//   inc_sel    - class receiving the vote
//   rd_sel     - class whose count is presented on rd_cnt_c
//   rd_cnt_c   - combinational read of the selected counter
module eva_vote_tally
    import eva_knn_pkg::*;
#(
    parameter int unsigned num_classes = NUM_CLASSES,
    parameter int unsigned label_w     = LABEL_W,
    parameter int unsigned cnt_w       = CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               inc,
    input  logic [label_w-1:0] inc_sel,
    input  logic [label_w-1:0] rd_sel,
    output logic [cnt_w-1:0]   rd_cnt_c
);

    logic [cnt_w-1:0] cnt [num_classes];

    // Counter storage; at most Number votes, so no saturation needed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(num_classes); i++) begin
                cnt[i] <= '0;
            end
        end else if (clear) begin
            for (int i = 0; i < int'(num_classes); i++) begin
                cnt[i] <= '0;
            end
        end else if (inc) begin
            cnt[inc_sel] <= cnt[inc_sel] + cnt_w'(1);
        end
    end

    assign rd_cnt_c = cnt[rd_sel];

endmodule

// File: rtl/eva_knn_vote.sv
// k-NN majority vote over the argsort result.
// On start (in IDLE) latches the sorted indices, labels and clamped k,
// tallies one vote per class over the first k_eff neighbours (COUNT),
// scans the tallies for the largest count with lowest-index tie-break
// (SCAN), then presents the result with a one-cycle done pulse (DONE).
// Ports:
//   clk, rst         - clock, asynchronous active-high reset
//   start            - sort-complete strobe, honoured only in IDLE
//   sorted_index_1D  - slice i is the index of the i-th nearest sample
//   labels           - slice j is the class of sample j
//   k                - neighbours to vote, sampled with start
//   busy             - high while the state is not IDLE
//   done             - one-cycle pulse when class_out/vote_count update
//   class_out        - winning class
//   vote_count       - votes held by class_out
module eva_knn_vote
    import eva_knn_pkg::*;
#(
    parameter int unsigned Number  = NUMBER,
    parameter int unsigned idx_w   = IDX_W,
    parameter int unsigned label_w = LABEL_W,
    parameter int unsigned cnt_w   = CNT_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [idx_w*Number-1:0]   sorted_index_1D,
    input  logic [label_w*Number-1:0] labels,
    input  logic [cnt_w-1:0]          k,
    output logic                      busy,
    output logic                      done,
    output logic [label_w-1:0]        class_out,
    output logic [cnt_w-1:0]          vote_count
);

    localparam int unsigned num_classes = 1 << label_w;

    state_t                    state_q, state_d;
    logic [idx_w*Number-1:0]   sorted_q, sorted_d;
    logic [label_w*Number-1:0] labels_q, labels_d;
    logic [cnt_w-1:0]          k_eff_q, k_eff_d;
    logic [cnt_w-1:0]          p_q, p_d;
    logic [label_w-1:0]        c_q, c_d;
    logic [label_w-1:0]        best_cls_q, best_cls_d;
    logic [cnt_w-1:0]          best_cnt_q, best_cnt_d;
    logic                      busy_d, done_d;
    logic [label_w-1:0]        class_out_d;
    logic [cnt_w-1:0]          vote_count_d;

    logic                      tally_clear_c;
    logic                      tally_inc_c;
    logic [label_w-1:0]        tally_sel_c;
    logic [cnt_w-1:0]          tally_rd_c;
    logic [label_w-1:0]        scan_cls_c;
    logic [cnt_w-1:0]          scan_cnt_c;

    logic [idx_w-1:0]   sorted_arr [Number];
    logic [label_w-1:0] labels_arr [Number];

    // Unpack the latched flat buses into indexable arrays.
    for (genvar i = 0; i < int'(Number); i++) begin : g_unpack
        assign sorted_arr[i] = sorted_q[idx_w*i +: idx_w];
        assign labels_arr[i] = labels_q[label_w*i +: label_w];
    end

    // Class of the p-th nearest sample.
    assign tally_sel_c = labels_arr[sorted_arr[idx_w'(p_q)]];

    // Strict compare keeps the earlier (lower) class on ties.
    assign scan_cls_c = (tally_rd_c > best_cnt_q) ? c_q : best_cls_q;
    assign scan_cnt_c = (tally_rd_c > best_cnt_q) ? tally_rd_c : best_cnt_q;

    eva_vote_tally #(
        .num_classes (num_classes),
        .label_w     (label_w),
        .cnt_w       (cnt_w)
    ) u_tally (
        .clk      (clk),
        .rst      (rst),
        .clear    (tally_clear_c),
        .inc      (tally_inc_c),
        .inc_sel  (tally_sel_c),
        .rd_sel   (c_q),
        .rd_cnt_c (tally_rd_c)
    );

    // Next-state and output decode.
    always_comb begin
        state_d       = state_q;
        sorted_d      = sorted_q;
        labels_d      = labels_q;
        k_eff_d       = k_eff_q;
        p_d           = p_q;
        c_d           = c_q;
        best_cls_d    = best_cls_q;
        best_cnt_d    = best_cnt_q;
        class_out_d   = class_out;
        vote_count_d  = vote_count;
        done_d        = 1'b0;
        tally_clear_c = 1'b0;
        tally_inc_c   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sorted_d      = sorted_index_1D;
                    labels_d      = labels;
                    k_eff_d       = cnt_w'(clamp_k(CNT_W'(k), Number));
                    p_d           = '0;
                    tally_clear_c = 1'b1;
                    state_d       = ST_COUNT;
                end
            end
            ST_COUNT: begin
                tally_inc_c = 1'b1;
                p_d         = p_q + cnt_w'(1);
                if (p_q == k_eff_q - cnt_w'(1)) begin
                    c_d        = '0;
                    best_cls_d = '0;
                    best_cnt_d = '0;
                    state_d    = ST_SCAN;
                end
            end
            ST_SCAN: begin
                best_cls_d = scan_cls_c;
                best_cnt_d = scan_cnt_c;
                c_d        = c_q + label_w'(1);
                if (c_q == label_w'(num_classes - 1)) begin
                    class_out_d  = scan_cls_c;
                    vote_count_d = scan_cnt_c;
                    done_d       = 1'b1;
                    state_d      = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            sorted_q   <= '0;
            labels_q   <= '0;
            k_eff_q    <= '0;
            p_q        <= '0;
            c_q        <= '0;
            best_cls_q <= '0;
            best_cnt_q <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            class_out  <= '0;
            vote_count <= '0;
        end else begin
            state_q    <= state_d;
            sorted_q   <= sorted_d;
            labels_q   <= labels_d;
            k_eff_q    <= k_eff_d;
            p_q        <= p_d;
            c_q        <= c_d;
            best_cls_q <= best_cls_d;
            best_cnt_q <= best_cnt_d;
            busy       <= busy_d;
            done       <= done_d;
            class_out  <= class_out_d;
            vote_count <= vote_count_d;
        end
    end

endmodule
